// File: rtl/lc3b_types.sv
// Shared LC-3b types for the cache slice: address field widths, word and tag types,
// and the cache controller state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [8:0]  lc3b_cache_tag;

    localparam int TAG_W    = 9;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_ctrl_state;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for cache statistics.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + {{(width-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back / write-allocate L1 cache: hit service,
// victim write-back, line fill and hit/miss statistics.
module cache_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [15:0]         mem_address,
    output logic                mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    output logic [15:0]         pmem_address,
    input  logic                hit,
    input  logic                set_one_hit,
    input  logic                set_two_hit,
    input  logic                set_one_valid,
    input  logic                set_two_valid,
    input  logic                set_one_dirty,
    input  logic                set_two_dirty,
    input  logic [8:0]          set_one_tag,
    input  logic [8:0]          set_two_tag,
    input  logic                current_lru,
    output logic                load_set_one,
    output logic                load_set_two,
    output logic                load_lru,
    output logic                cache_in_mux_sel,
    output logic                insert_mux_sel,
    output logic                write_type_set_one,
    output logic                write_type_set_two,
    output logic                pmem_w_mux_sel,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    cache_ctrl_state            r_state;
    logic                       r_victim;
    logic                       r_refill;
    logic [TAG_W+INDEX_W-1:0]   r_line;
    lc3b_cache_tag              r_wb_tag;

    logic w_req;
    logic w_check_hit;
    logic w_miss;
    logic w_hit_inc;
    logic w_victim_next;
    logic w_victim_dirty;
    logic w_unused_offset;

    assign w_req       = mem_read | mem_write;
    assign w_check_hit = (r_state == CHECK) && w_req && hit;
    assign w_miss      = (r_state == CHECK) && w_req && !hit;
    assign w_hit_inc   = w_check_hit && !r_refill;

    // An invalid way is always preferred over evicting the LRU line.
    assign w_victim_next  = !set_one_valid ? 1'b0 :
                            !set_two_valid ? 1'b1 : current_lru;
    assign w_victim_dirty = w_victim_next ? (set_two_valid & set_two_dirty)
                                          : (set_one_valid & set_one_dirty);

    assign w_unused_offset = &mem_address[OFFSET_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= CHECK;
            r_victim <= 1'b0;
            r_refill <= 1'b0;
            r_line   <= '0;
            r_wb_tag <= '0;
        end else begin
            case (r_state)
                CHECK: begin
                    r_refill <= 1'b0;
                    if (w_miss) begin
                        r_victim <= w_victim_next;
                        r_line   <= mem_address[15:OFFSET_W];
                        r_wb_tag <= w_victim_next ? set_two_tag : set_one_tag;
                        r_state  <= w_victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_state  <= CHECK;
                        r_refill <= 1'b1;
                    end
                end
                default: r_state <= CHECK;
            endcase
        end
    end

    always_comb begin
        mem_resp           = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        pmem_address       = {mem_address[15:OFFSET_W], 4'h0};
        load_set_one       = 1'b0;
        load_set_two       = 1'b0;
        load_lru           = 1'b0;
        cache_in_mux_sel   = 1'b0;
        insert_mux_sel     = 1'b0;
        write_type_set_one = 1'b0;
        write_type_set_two = 1'b0;
        pmem_w_mux_sel     = 1'b0;
        case (r_state)
            CHECK: begin
                if (w_check_hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    if (mem_write) begin
                        cache_in_mux_sel = 1'b1;
                        if (set_one_hit) begin
                            load_set_one       = 1'b1;
                            write_type_set_one = 1'b1;
                        end else if (set_two_hit) begin
                            load_set_two       = 1'b1;
                            write_type_set_two = 1'b1;
                        end
                    end
                end
            end
            WRITEBACK: begin
                pmem_write     = 1'b1;
                pmem_w_mux_sel = r_victim;
                pmem_address   = {r_wb_tag, r_line[INDEX_W-1:0], 4'h0};
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {r_line, 4'h0};
                // The refilled line is always clean; a pending write dirties it on the following hit.
                if (pmem_resp) begin
                    load_set_one = !r_victim;
                    load_set_two = r_victim;
                end
            end
            default: ;
        endcase
    end

    sat_counter #(.width(CNT_W)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.width(CNT_W)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_miss),
        .count (miss_count)
    );

endmodule
